// File: rtl/qnigma_ext_port_pkg.sv
// Shared operand-interface types for the qnigma external port.
package qnigma_ext_port_pkg;

  localparam int POINT_IFC_BITS = 256;
  localparam int WORDS_PER_OPER = POINT_IFC_BITS / 8;

  typedef logic [7:0] wrd_t;
  typedef logic [2:0] ptr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM,
    WAIT
  } ext_rd_fsm_t;

endpackage

// File: rtl/qnigma_ext_ram.sv
// Operand RAM: one write port, one registered read port, read-first on collision.
module qnigma_ext_ram
  import qnigma_ext_port_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int ADR_W  = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADR_W-1:0]  wr_adr,
  input  logic [WORD_W-1:0] wr_dat,
  input  logic [ADR_W-1:0]  rd_adr,
  output logic [WORD_W-1:0] rd_dat
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rd_dat_q;

  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_adr] <= wr_dat;
    rd_dat_q <= mem_q[rd_adr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/qnigma_ext_port.sv
// Operand endpoint: byte-serial writes into the operand RAM, framed byte-serial reads out,
// plus a core read port that takes priority over the external read FSM.
// state  | meaning
// IDLE   | no stream; waiting for ext_rd_req
// FETCH  | RAM read of the current word; repeats while the core owns the read port
// STREAM | word presented with ext_rd_val (eof on the last word)
// WAIT   | AUTO=0 hold until ext_rd_nxt
module qnigma_ext_port
  import qnigma_ext_port_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int WORDS  = WORDS_PER_OPER,
  parameter int SLOTS  = 8,
  parameter bit AUTO   = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [WORD_W-1:0]                      ext_wr_dat,
  input  logic [$clog2(SLOTS)-1:0]               ext_wr_ptr,
  input  logic                                   ext_wr_val,
  input  logic                                   ext_wr_sof,
  output logic                                   wr_done,
  input  logic                                   ext_rd_req,
  input  logic [$clog2(SLOTS)-1:0]               ext_rd_ptr,
  input  logic                                   ext_rd_nxt,
  output logic [WORD_W-1:0]                      ext_rd_dat,
  output logic                                   ext_rd_val,
  output logic                                   ext_rd_eof,
  output logic                                   rd_busy,
  input  logic                                   core_rd_req,
  input  logic [$clog2(SLOTS)+$clog2(WORDS)-1:0] core_rd_adr,
  output logic [WORD_W-1:0]                      core_rd_dat
);

  localparam int PTR_W = $clog2(SLOTS);
  localparam int IDX_W = $clog2(WORDS);
  localparam int ADR_W = PTR_W + IDX_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  logic [PTR_W-1:0]  wr_slot_q, wr_slot_d;
  logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]  wr_idx;
  logic              wr_done_q, wr_done_d;
  logic              wr_sof;
  logic [ADR_W-1:0]  wr_adr;

  ext_rd_fsm_t       state_q, state_d;
  logic [PTR_W-1:0]  rd_slot_q, rd_slot_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              core_vld_q, core_vld_d;
  logic              rd_last;
  logic [ADR_W-1:0]  ram_rd_adr;
  logic [WORD_W-1:0] ram_rd_dat;

  // Write side: sof restarts at word 0 of the new slot; the counter wraps after the last word.
  always_comb begin
    wr_sof    = ext_wr_val & ext_wr_sof;
    wr_idx    = wr_sof ? '0 : wr_cnt_q;
    wr_slot_d = wr_sof ? ext_wr_ptr : wr_slot_q;
    wr_adr    = {wr_slot_d, wr_idx};
    wr_cnt_d  = wr_cnt_q;
    if (ext_wr_val) wr_cnt_d = (wr_idx == IDX_LAST) ? '0 : wr_idx + 1'b1;
    wr_done_d = ext_wr_val && (wr_idx == IDX_LAST);
  end

  assign rd_last    = (rd_idx_q == IDX_LAST);
  assign core_vld_d = core_rd_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rd_slot_q  <= '0;
      rd_idx_q   <= '0;
      wr_slot_q  <= '0;
      wr_cnt_q   <= '0;
      wr_done_q  <= 1'b0;
      core_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_slot_q  <= rd_slot_d;
      rd_idx_q   <= rd_idx_d;
      wr_slot_q  <= wr_slot_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_done_q  <= wr_done_d;
      core_vld_q <= core_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_slot_d = rd_slot_q;
    rd_idx_d  = rd_idx_q;
    case (state_q)
      IDLE: begin
        if (ext_rd_req) begin
          state_d   = FETCH;
          rd_slot_d = ext_rd_ptr;
          rd_idx_d  = '0;
        end
      end
      FETCH: begin
        if (!core_rd_req) state_d = STREAM;
      end
      STREAM: begin
        if (rd_last) begin
          state_d  = IDLE;
          rd_idx_d = '0;
        end else if (AUTO || ext_rd_nxt) begin
          state_d  = FETCH;
          rd_idx_d = rd_idx_q + 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ext_rd_nxt) begin
          state_d  = FETCH;
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Core owns the shared read port whenever it asks; the FSM's FETCH simply retries.
  assign ram_rd_adr = core_rd_req ? core_rd_adr : {rd_slot_q, rd_idx_q};

  always_comb begin
    ext_rd_val  = (state_q == STREAM);
    ext_rd_eof  = ext_rd_val && rd_last;
    ext_rd_dat  = ext_rd_val ? ram_rd_dat : '0;
    rd_busy     = (state_q != IDLE);
    core_rd_dat = core_vld_q ? ram_rd_dat : '0;
    wr_done     = wr_done_q;
  end

  qnigma_ext_ram #(
    .WORD_W (WORD_W),
    .ADR_W  (ADR_W),
    .DEPTH  (SLOTS * WORDS)
  ) u_ram (
    .clk    (clk),
    .wr_en  (ext_wr_val),
    .wr_adr (wr_adr),
    .wr_dat (ext_wr_dat),
    .rd_adr (ram_rd_adr),
    .rd_dat (ram_rd_dat)
  );

endmodule

// File: tb/tb_qnigma_ext_port.sv
// Scoreboard bench for qnigma_ext_port: one AUTO=1 and one AUTO=0 instance share the write/core side.
module tb_qnigma_ext_port;

  typedef struct {
    logic [7:0] dat;
    logic       eof;
    int         cyc;
  } exp_t;

  localparam logic [255:0] BOB =
    256'hde9edb7d7b7dc1b4d35b61c2ece435373f8343c85b78674dadfc7e146f882b4f;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] wr_dat = '0;
  logic [2:0] wr_ptr = '0;
  logic       wr_val = 1'b0;
  logic       wr_sof = 1'b0;
  logic       core_req = 1'b0;
  logic [7:0] core_adr = '0;

  logic       rd_req_a = 1'b0, rd_req_m = 1'b0;
  logic [2:0] rd_ptr_a = '0, rd_ptr_m = '0;
  logic       nxt_a = 1'b0, nxt_m = 1'b0;

  logic       done_a, done_m;
  logic [7:0] dat_a, dat_m, cdat_a, cdat_m;
  logic       val_a, val_m, eof_a, eof_m, busy_a, busy_m;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_wr_cyc = 0;
  logic [255:0] acc_a = '0;

  exp_t q_a[$];
  exp_t q_m[$];
  exp_t q_c[$];

  qnigma_ext_port #(.AUTO(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .ext_wr_dat(wr_dat), .ext_wr_ptr(wr_ptr), .ext_wr_val(wr_val), .ext_wr_sof(wr_sof),
    .wr_done(done_a),
    .ext_rd_req(rd_req_a), .ext_rd_ptr(rd_ptr_a), .ext_rd_nxt(nxt_a),
    .ext_rd_dat(dat_a), .ext_rd_val(val_a), .ext_rd_eof(eof_a), .rd_busy(busy_a),
    .core_rd_req(core_req), .core_rd_adr(core_adr), .core_rd_dat(cdat_a)
  );

  qnigma_ext_port #(.AUTO(1'b0)) dut_m (
    .clk(clk), .rst(rst),
    .ext_wr_dat(wr_dat), .ext_wr_ptr(wr_ptr), .ext_wr_val(wr_val), .ext_wr_sof(wr_sof),
    .wr_done(done_m),
    .ext_rd_req(rd_req_m), .ext_rd_ptr(rd_ptr_m), .ext_rd_nxt(nxt_m),
    .ext_rd_dat(dat_m), .ext_rd_val(val_m), .ext_rd_eof(eof_m), .rd_busy(busy_m),
    .core_rd_req(core_req), .core_rd_adr(core_adr), .core_rd_dat(cdat_m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitors: pop and compare whenever a stream word or core word appears.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst && val_a) begin
      acc_a = {dat_a, acc_a[255:8]};
      if (q_a.size() == 0) check("a_unexpected_val", 1, 0);
      else begin
        e = q_a.pop_front();
        check("a_dat", dat_a, e.dat);
        check("a_eof", eof_a, e.eof);
        check("a_val_cycle", cyc, e.cyc);
      end
    end
    if (rst && eof_a && !val_a) check("a_eof_without_val", 1, 0);
  end

  always @(negedge clk) begin : mon_m
    exp_t e;
    if (rst && val_m) begin
      if (q_m.size() == 0) check("m_unexpected_val", 1, 0);
      else begin
        e = q_m.pop_front();
        check("m_dat", dat_m, e.dat);
        check("m_eof", eof_m, e.eof);
        check("m_val_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (q_c.size() != 0 && q_c[0].cyc <= cyc) begin
      e = q_c.pop_front();
      if (e.cyc < cyc) check("core_missed", cyc, e.cyc);
      else check("core_dat", cdat_a, e.dat);
    end
  end

  always @(negedge clk) begin : mon_done
    if (done_a === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_oper(input logic [2:0] slot, input logic [255:0] v);
    for (int i = 0; i < 32; i++) begin
      wr_val = 1'b1;
      wr_sof = (i == 0);
      wr_ptr = (i == 0) ? slot : 3'd0;
      wr_dat = v[8*i +: 8];
      if (i == 31) last_wr_cyc = cyc;
      tick();
    end
    wr_val = 1'b0;
    wr_sof = 1'b0;
  endtask

  task automatic push_a(input logic [255:0] v, input int t, input int n, input int stall_k, input int stall_n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.dat = v[8*k +: 8];
      e.eof = (k == 31);
      e.cyc = t + 2 + 2 * k + ((k >= stall_k) ? stall_n : 0);
      q_a.push_back(e);
    end
  endtask

  task automatic start_a(input logic [2:0] slot);
    rd_ptr_a = slot;
    rd_req_a = 1'b1;
    tick();
    rd_req_a = 1'b0;
  endtask

  task automatic wait_fall(input bit sel_m, input int exp_cyc, input string nm);
    for (int i = 0; i < 400 && (sel_m ? busy_m : busy_a); i++) tick();
    if (sel_m ? busy_m : busy_a) check({nm, "_timeout"}, 1, 0);
    else check(nm, cyc, exp_cyc);
  endtask

  initial begin : stim
    logic [255:0] v3, v6;
    int t;
    int d0;
    exp_t e;

    for (int i = 0; i < 32; i++) begin
      v3[8*i +: 8] = 8'(i);
      v6[8*i +: 8] = 8'(8'hA0 + i);
    end
    v6[7:0] = 8'h77;

    repeat (3) tick();
    check("rst_val",      {val_a, val_m}, 2'b00);
    check("rst_eof",      {eof_a, eof_m}, 2'b00);
    check("rst_busy",     {busy_a, busy_m}, 2'b00);
    check("rst_wr_done",  {done_a, done_m}, 2'b00);
    check("rst_dat",      {dat_a, dat_m, cdat_a}, 24'h0);
    rst = 1'b1;
    tick();

    // Slot 3 <- 0x00..0x1F, then AUTO read-back.
    wr_oper(3'd3, v3);
    repeat (2) tick();
    check("wr_done_count", done_cnt, 1);
    check("wr_done_cycle", done_cyc, last_wr_cyc + 1);
    t = cyc;
    push_a(v3, t, 32, 99, 0);
    start_a(3'd3);
    wait_fall(1'b0, t + 65, "a_busy_fall");

    // RFC7748 Bob public key, little-endian bytes.
    wr_oper(3'd5, BOB);
    repeat (2) tick();
    acc_a = '0;
    t = cyc;
    push_a(BOB, t, 32, 99, 0);
    start_a(3'd5);
    wait_fall(1'b0, t + 65, "bob_busy_fall");
    check("bob_reassembled", acc_a, BOB);

    // AUTO=0: one nxt pulse every 5 cycles.
    t = cyc;
    for (int k = 0; k < 32; k++) begin
      e.dat = 8'(k);
      e.eof = (k == 31);
      e.cyc = (k == 0) ? t + 2 : t + 5 * k + 2;
      q_m.push_back(e);
    end
    rd_ptr_m = 3'd3;
    rd_req_m = 1'b1;
    tick();
    rd_req_m = 1'b0;
    for (int j = 1; j < 32; j++) begin
      repeat (t + 5 * j - cyc) tick();
      nxt_m = 1'b1;
      tick();
      nxt_m = 1'b0;
    end
    wait_fall(1'b1, t + 158, "m_busy_fall");

    // Core holds the read port for 4 cycles starting on the FETCH of word 4.
    t = cyc;
    push_a(v3, t, 32, 4, 4);
    for (int i = 1; i <= 4; i++) begin
      e.dat = 8'h05;
      e.eof = 1'b0;
      e.cyc = t + 9 + i;
      q_c.push_back(e);
    end
    start_a(3'd3);
    while (cyc < t + 9) tick();
    core_req = 1'b1;
    core_adr = {3'd3, 5'd5};
    repeat (4) tick();
    core_req = 1'b0;
    wait_fall(1'b0, t + 69, "core_stall_busy_fall");

    // Re-request mid-stream must be ignored.
    t = cyc;
    push_a(v3, t, 32, 99, 0);
    start_a(3'd3);
    while (cyc < t + 20) tick();
    rd_ptr_a = 3'd5;
    rd_req_a = 1'b1;
    tick();
    rd_req_a = 1'b0;
    wait_fall(1'b0, t + 65, "rereq_busy_fall");

    // Reset during word 10, then a fresh read starts again at word 0.
    t = cyc;
    push_a(v3, t, 10, 99, 0);
    start_a(3'd3);
    while (cyc < t + 22) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_mid_val",  val_a, 1'b0);
    check("rst_mid_eof",  eof_a, 1'b0);
    check("rst_mid_busy", busy_a, 1'b0);
    check("rst_mid_queue", q_a.size(), 0);
    tick();
    t = cyc;
    push_a(v3, t, 32, 99, 0);
    start_a(3'd3);
    wait_fall(1'b0, t + 65, "restart_busy_fall");

    // sof + 32 un-framed words: the 33rd lands on word 0 of the same slot.
    d0 = done_cnt;
    wr_oper(3'd6, v6 ^ 256'hD7);
    wr_val = 1'b1;
    wr_dat = 8'h77;
    tick();
    wr_val = 1'b0;
    repeat (3) tick();
    check("wrap_wr_done_count", done_cnt, d0 + 1);
    t = cyc;
    push_a(v6, t, 32, 99, 0);
    start_a(3'd6);
    wait_fall(1'b0, t + 65, "wrap_busy_fall");

    repeat (3) tick();
    check("a_queue_drained", q_a.size(), 0);
    check("m_queue_drained", q_m.size(), 0);
    check("core_queue_drained", q_c.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
